// File: rtl/data_cache_if.sv
// ---------------------------------------------------------------------------
// data_cache_if
// Bundles the load port, the store-commit port and the memory port of
// data_cache.
//   slave  modport : the cache side (takes requests, drives done/data and
//                    the memory request).
//   master modport : the environment side (load/store unit, ROB and memory).
// Signals:
//   dcache_read, dcache_read_addr           load request (held until done)
//   dcache_read_done, dcache_read_data      one-cycle load completion + word
//   dcache_write, dcache_write_addr/data/mask  store commit (held until done)
//   dcache_write_done                       one-cycle store completion
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wmask   memory request
//   mem_ack, mem_rdata                      one-cycle memory completion
// ---------------------------------------------------------------------------
interface data_cache_if;
  logic        dcache_read;
  logic [31:0] dcache_read_addr;
  logic        dcache_read_done;
  logic [31:0] dcache_read_data;

  logic        dcache_write;
  logic [31:0] dcache_write_addr;
  logic [31:0] dcache_write_data;
  logic [3:0]  dcache_write_mask;
  logic        dcache_write_done;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  dcache_read, dcache_read_addr,
    output dcache_read_done, dcache_read_data,
    input  dcache_write, dcache_write_addr, dcache_write_data, dcache_write_mask,
    output dcache_write_done,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport master (
    output dcache_read, dcache_read_addr,
    input  dcache_read_done, dcache_read_data,
    output dcache_write, dcache_write_addr, dcache_write_data, dcache_write_mask,
    input  dcache_write_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data
// cache between a load/store unit and a simple ack-based memory.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   dc         data_cache_if.slave: load port, store port, memory port
//   hit_count  (DCACHE_STATS_EN only) saturating count of read hits
//   miss_count (DCACHE_STATS_EN only) saturating count of read misses
//
// Parameters:
//   LINES    number of lines (power of two)
//   INDEX_W  log2(LINES)
//
// Optional build macro: DCACHE_STATS_EN adds the hit/miss counters and their
// output ports. Without it the cache behaves identically, minus the counters.
//
// Behaviour summary:
//   IDLE  : store pending -> WRITE (stores win over loads);
//           load hit -> RESP (line word latched); load miss -> MISS.
//   RESP  : one-cycle read_done with the latched word.
//   MISS  : memory read until ack; ack fills the line and is also the
//           read_done cycle (mem_rdata forwarded straight through).
//   WRITE : memory write until ack; ack updates the line on a tag hit
//           (masked bytes only) and pulses write_done.
//   Every done returns to IDLE, so a request still held high is re-examined
//   only after a full IDLE cycle.
// ---------------------------------------------------------------------------
module data_cache #(
  parameter int LINES   = 16,
  parameter int INDEX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave dc
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    MISS,
    WRITE
  } state_t;

  state_t state_reg, state_next;

  // Line storage. Valid bits are flops so reset can clear them all at once;
  // tags and data carry no reset.
  logic [LINES-1:0] valid_reg;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // Transaction registers captured when leaving IDLE; they keep the memory
  // request stable for the whole MISS/WRITE even if the port wiggles.
  logic [29:0] word_addr_reg;   // word address (byte address >> 2)
  logic [31:0] wdata_reg;
  logic [3:0]  mask_reg;
  logic [31:0] resp_data_reg;   // word returned in RESP

  // -------------------------------------------------------------------------
  // Lookup for the incoming load (decides RESP vs MISS while in IDLE)
  // -------------------------------------------------------------------------
  logic [INDEX_W-1:0] rd_index;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_hit;

  assign rd_index = dc.dcache_read_addr[INDEX_W+1:2];
  assign rd_tag   = dc.dcache_read_addr[31:INDEX_W+2];
  assign rd_hit   = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);

  // -------------------------------------------------------------------------
  // Lookup for the in-flight transaction (line fill / store update on ack)
  // -------------------------------------------------------------------------
  logic [INDEX_W-1:0] txn_index;
  logic [TAG_W-1:0]   txn_tag;
  logic               txn_hit;
  logic [31:0]        txn_word;
  logic [31:0]        merged_word;

  assign txn_index = word_addr_reg[INDEX_W-1:0];
  assign txn_tag   = word_addr_reg[29:INDEX_W];
  assign txn_hit   = valid_reg[txn_index] && (tag_mem[txn_index] == txn_tag);
  assign txn_word  = data_mem[txn_index];

  // Byte merge for a store hit: only enabled bytes take the store data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_word[8*gi +: 8] = mask_reg[gi] ? wdata_reg[8*gi +: 8]
                                                 : txn_word[8*gi +: 8];
  end

  // Line-update strobes. Gated by rst so a reset that lands on the ack
  // cycle still abandons the transaction.
  logic fill_en;
  logic store_hit_en;

  assign fill_en      = (state_reg == MISS)  && dc.mem_ack && !rst;
  assign store_hit_en = (state_reg == WRITE) && dc.mem_ack && txn_hit && !rst;

  // Start-of-transaction decode, shared by the registers and the counters.
  logic start_write;
  logic start_read_hit;
  logic start_read_miss;

  assign start_write     = (state_reg == IDLE) && dc.dcache_write;
  assign start_read_hit  = (state_reg == IDLE) && !dc.dcache_write &&
                           dc.dcache_read && rd_hit;
  assign start_read_miss = (state_reg == IDLE) && !dc.dcache_write &&
                           dc.dcache_read && !rd_hit;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next           = state_reg;
    dc.dcache_read_done  = 1'b0;
    dc.dcache_read_data  = 32'd0;
    dc.dcache_write_done = 1'b0;
    dc.mem_req           = 1'b0;
    dc.mem_we            = 1'b0;
    dc.mem_addr          = 32'd0;
    dc.mem_wdata         = 32'd0;
    dc.mem_wmask         = 4'd0;

    case (state_reg)
      IDLE: begin
        if (dc.dcache_write) begin
          state_next = WRITE;
        end else if (dc.dcache_read) begin
          state_next = rd_hit ? RESP : MISS;
        end
      end

      RESP: begin
        dc.dcache_read_done = 1'b1;
        dc.dcache_read_data = resp_data_reg;
        state_next          = IDLE;
      end

      MISS: begin
        dc.mem_req  = 1'b1;
        dc.mem_addr = {word_addr_reg, 2'b00};
        if (dc.mem_ack) begin
          // Forward the fill word in the ack cycle instead of waiting a
          // cycle for the line to be written.
          dc.dcache_read_done = 1'b1;
          dc.dcache_read_data = dc.mem_rdata;
          state_next          = IDLE;
        end
      end

      WRITE: begin
        dc.mem_req   = 1'b1;
        dc.mem_we    = 1'b1;
        dc.mem_addr  = {word_addr_reg, 2'b00};
        dc.mem_wdata = wdata_reg;
        dc.mem_wmask = mask_reg;
        if (dc.mem_ack) begin
          dc.dcache_write_done = 1'b1;
          state_next           = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Reset overrides everything the same cycle: no done, no memory request.
    if (rst) begin
      state_next           = IDLE;
      dc.dcache_read_done  = 1'b0;
      dc.dcache_read_data  = 32'd0;
      dc.dcache_write_done = 1'b0;
      dc.mem_req           = 1'b0;
      dc.mem_we            = 1'b0;
      dc.mem_addr          = 32'd0;
      dc.mem_wdata         = 32'd0;
      dc.mem_wmask         = 4'd0;
    end
  end

  // -------------------------------------------------------------------------
  // Transaction capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      word_addr_reg <= 30'd0;
      wdata_reg     <= 32'd0;
      mask_reg      <= 4'd0;
      resp_data_reg <= 32'd0;
    end else if (start_write) begin
      word_addr_reg <= dc.dcache_write_addr[31:2];
      wdata_reg     <= dc.dcache_write_data;
      mask_reg      <= dc.dcache_write_mask;
    end else if (start_read_hit || start_read_miss) begin
      word_addr_reg <= dc.dcache_read_addr[31:2];
      if (start_read_hit) begin
        resp_data_reg <= data_mem[rd_index];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Valid bits
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (fill_en) begin
      valid_reg[txn_index] <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Tag and data arrays. A fill replaces the whole line; a store hit
  // rewrites the data word with the masked merge and leaves the tag alone.
  // Store misses never touch the arrays (no write-allocate).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[txn_index]  <= txn_tag;
      data_mem[txn_index] <= dc.mem_rdata;
    end else if (store_hit_en) begin
      data_mem[txn_index] <= merged_word;
    end
  end

`ifdef DCACHE_STATS_EN
  // -------------------------------------------------------------------------
  // Read hit/miss statistics, counted at the IDLE decision, saturating.
  // -------------------------------------------------------------------------
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_reg  <= 32'd0;
      miss_count_reg <= 32'd0;
    end else begin
      if (start_read_hit && (hit_count_reg != 32'hFFFF_FFFF)) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      if (start_read_miss && (miss_count_reg != 32'hFFFF_FFFF)) begin
        miss_count_reg <= miss_count_reg + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_data_cache.sv
// ---------------------------------------------------------------------------
// tb_data_cache
// Self-checking bench for data_cache. A behavioural memory answers mem_req
// after a fixed latency; a scoreboard queue holds the expected completions
// and is popped whenever the cache pulses a done. The main sequence walks a
// vector table and then a few hand-written multi-cycle scenarios.
// ---------------------------------------------------------------------------
module tb_data_cache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_cache_if ifc ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache #(
    .LINES   (16),
    .INDEX_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dc  (ifc)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_write;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  // ---------------- memory model ----------------
  logic [31:0] mem_model [0:1023];
  bit          mem_auto     = 1'b1;
  bit          manual_ack   = 1'b0;
  logic [31:0] manual_rdata = 32'd0;
  int          ack_delay    = 3;
  int          mem_reads    = 0;
  int          mem_writes   = 0;
  int          mem_req_cycles = 0;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_mask;
  logic        last_we;

  task automatic check32(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Memory responder: acts 1 time unit after each rising edge.
  initial begin : responder
    int          wait_cnt;
    logic [31:0] first_addr;
    logic        first_we;
    logic [3:0]  first_mask;
    logic [31:0] first_wdata;
    int          idx;
    wait_cnt = 0;
    ifc.mem_ack   = 1'b0;
    ifc.mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_auto) begin
        ifc.mem_ack   = manual_ack;
        ifc.mem_rdata = manual_rdata;
        wait_cnt      = 0;
      end else if (ifc.mem_ack) begin
        ifc.mem_ack   = 1'b0;
        ifc.mem_rdata = 32'd0;
        wait_cnt      = 0;
      end else if (ifc.mem_req === 1'b1) begin
        mem_req_cycles++;
        if (wait_cnt == 0) begin
          first_addr  = ifc.mem_addr;
          first_we    = ifc.mem_we;
          first_mask  = ifc.mem_wmask;
          first_wdata = ifc.mem_wdata;
        end
        wait_cnt++;
        if (wait_cnt == ack_delay) begin
          check32("mem_stable", {ifc.mem_addr[31:0] ^ first_addr,
                  3'b000, ifc.mem_we ^ first_we, ifc.mem_wmask ^ first_mask,
                  24'd0} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
          if (ifc.mem_we && (ifc.mem_wdata !== first_wdata)) begin
            check32("mem_wdata_stable", ifc.mem_wdata, first_wdata);
          end
          idx        = int'(ifc.mem_addr[11:2]);
          last_addr  = ifc.mem_addr;
          last_we    = ifc.mem_we;
          last_mask  = ifc.mem_wmask;
          last_wdata = ifc.mem_wdata;
          if (ifc.mem_we) begin
            for (int b = 0; b < 4; b++) begin
              if (ifc.mem_wmask[b]) mem_model[idx][8*b +: 8] = ifc.mem_wdata[8*b +: 8];
            end
            mem_writes++;
          end else begin
            ifc.mem_rdata = mem_model[idx];
            mem_reads++;
          end
          ifc.mem_ack = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Done monitor: every done pulse must match the oldest expectation.
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (ifc.dcache_read_done === 1'b1 || ifc.dcache_write_done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done read_done=%b write_done=%b expected no done",
                   ifc.dcache_read_done, ifc.dcache_write_done);
        end else begin
          e = sb.pop_front();
          check32("done_kind", {31'd0, ifc.dcache_write_done}, {31'd0, e.is_write});
          if (!e.is_write) check32("read_data", ifc.dcache_read_data, e.data);
        end
      end
    end
  end

  // Overall time bound.
  initial begin
    #500000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- request tasks ----------------
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp,
                         input bit exp_miss);
    int reads0, reqc0, lat;
    bit seen;
    reads0 = mem_reads;
    reqc0  = mem_req_cycles;
    @(negedge clk);
    ifc.dcache_read      = 1'b1;
    ifc.dcache_read_addr = addr;
    sb.push_back('{1'b0, exp});
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (ifc.dcache_read_done === 1'b1) seen = 1'b1;
    end
    ifc.dcache_read = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL read_timeout addr %h got no done expected done", addr);
      sb.delete();
    end
    if (exp_miss) begin
      check32("miss_mem_reads", 32'(mem_reads - reads0), 32'd1);
      check32("miss_mem_addr", last_addr, {addr[31:2], 2'b00});
    end else begin
      check32("hit_no_mem_req", 32'(mem_req_cycles - reqc0), 32'd0);
      check32("hit_latency", 32'(lat), 32'd1);
    end
    $display("READ  addr=%h exp_data=%h %s latency=%0d", addr, exp,
             exp_miss ? "miss" : "hit", lat);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask);
    int writes0;
    bit seen;
    writes0 = mem_writes;
    @(negedge clk);
    ifc.dcache_write      = 1'b1;
    ifc.dcache_write_addr = addr;
    ifc.dcache_write_data = data;
    ifc.dcache_write_mask = mask;
    sb.push_back('{1'b1, 32'd0});
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ifc.dcache_write_done === 1'b1) seen = 1'b1;
    end
    ifc.dcache_write = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL write_timeout addr %h got no done expected done", addr);
      sb.delete();
    end
    check32("wr_mem_writes", 32'(mem_writes - writes0), 32'd1);
    check32("wr_mem_addr", last_addr, {addr[31:2], 2'b00});
    check32("wr_mem_data", last_wdata, data);
    check32("wr_mem_mask", {28'd0, last_mask}, {28'd0, mask});
    $display("WRITE addr=%h data=%h mask=%b", addr, data, mask);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_data;
    bit          exp_miss;
  } vec_t;
  vec_t vecs[13];

  initial begin : main
    int wseen, rseen, reads0, writes0;

    for (int i = 0; i < 1024; i++) mem_model[i] = {16'hC0DE, 16'(i * 4)};
    mem_model[16] = 32'hDEAD_BEEF;   // word 0x40

    //              wr   addr          wdata          mask     exp_data       miss
    vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b1};
    vecs[1]  = '{1'b0, 32'h0000_0042, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0040, 32'h0000_1200, 4'b0010, 32'h0,         1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'hDEAD_12EF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0440, 32'hAABB_CCDD, 4'b1111, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'hDEAD_12EF, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0440, 32'h0,         4'b0000, 32'hAABB_CCDD, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'hDEAD_12EF, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0044, 32'h0,         4'b0000, 32'hC0DE_0044, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0047, 32'h1122_3344, 4'b1001, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 32'h0000_0044, 32'h0,         4'b0000, 32'h11DE_0044, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_003C, 32'h0,         4'b0000, 32'hC0DE_003C, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_003C, 32'h0,         4'b0000, 32'hC0DE_003C, 1'b0};

    ifc.dcache_read       = 1'b0;
    ifc.dcache_read_addr  = 32'd0;
    ifc.dcache_write      = 1'b0;
    ifc.dcache_write_addr = 32'd0;
    ifc.dcache_write_data = 32'd0;
    ifc.dcache_write_mask = 4'd0;
    rst = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check32("rst_read_done", {31'd0, ifc.dcache_read_done}, 32'd0);
    check32("rst_write_done", {31'd0, ifc.dcache_write_done}, 32'd0);
    check32("rst_mem_req", {31'd0, ifc.mem_req}, 32'd0);
    check32("rst_mem_we", {31'd0, ifc.mem_we}, 32'd0);
    check32("rst_read_data", ifc.dcache_read_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check32("idle_mem_req", {31'd0, ifc.mem_req}, 32'd0);
`ifdef DCACHE_STATS_EN
    check32("rst_hit_count", hit_count, 32'd0);
    check32("rst_miss_count", miss_count, 32'd0);
`endif

    // ---- table ----
    for (int v = 0; v < 13; v++) begin
      if (vecs[v].is_write) do_write(vecs[v].addr, vecs[v].wdata, vecs[v].mask);
      else do_read(vecs[v].addr, vecs[v].exp_data, vecs[v].exp_miss);
    end
`ifdef DCACHE_STATS_EN
    check32("tbl_hit_count", hit_count, 32'd5);
    check32("tbl_miss_count", miss_count, 32'd5);
`endif

    // ---- simultaneous store 0x100 and load 0x80: store first ----
    reads0  = mem_reads;
    writes0 = mem_writes;
    @(negedge clk);
    sb.push_back('{1'b1, 32'd0});
    sb.push_back('{1'b0, 32'hC0DE_0080});
    ifc.dcache_write      = 1'b1;
    ifc.dcache_write_addr = 32'h0000_0100;
    ifc.dcache_write_data = 32'h0F0F_0F0F;
    ifc.dcache_write_mask = 4'b1111;
    ifc.dcache_read       = 1'b1;
    ifc.dcache_read_addr  = 32'h0000_0080;
    wseen = 0;
    rseen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ifc.dcache_write_done === 1'b1) begin
        wseen++;
        ifc.dcache_write = 1'b0;
      end
      if (ifc.dcache_read_done === 1'b1) begin
        rseen++;
        ifc.dcache_read = 1'b0;
      end
    end
    check32("simul_write_dones", 32'(wseen), 32'd1);
    check32("simul_read_dones", 32'(rseen), 32'd1);
    check32("simul_mem_writes", 32'(mem_writes - writes0), 32'd1);
    check32("simul_mem_reads", 32'(mem_reads - reads0), 32'd1);
    $display("SIMUL store 0x100 + load 0x80 write_dones=%0d read_dones=%0d", wseen, rseen);
    do_read(32'h0000_0080, 32'hC0DE_0080, 1'b0);
    do_read(32'h0000_0100, 32'h0F0F_0F0F, 1'b1);   // store miss did not allocate

    // ---- reset in MISS, ack arrives afterwards ----
    mem_auto = 1'b0;
    @(negedge clk);
    ifc.dcache_read      = 1'b1;
    ifc.dcache_read_addr = 32'h0000_00C0;
    @(negedge clk);
    @(negedge clk);
    check32("miss_mem_req_pending", {31'd0, ifc.mem_req}, 32'd1);
    rst             = 1'b1;
    ifc.dcache_read = 1'b0;
    @(negedge clk);
    rst          = 1'b0;
    manual_ack   = 1'b1;
    manual_rdata = 32'h1234_5678;
    check32("after_rst_mem_req", {31'd0, ifc.mem_req}, 32'd0);
    @(negedge clk);
    manual_ack   = 1'b0;
    manual_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check32("after_ack_mem_req", {31'd0, ifc.mem_req}, 32'd0);
    check32("after_ack_read_data", ifc.dcache_read_data, 32'd0);
`ifdef DCACHE_STATS_EN
    check32("rst_miss_hit_count", hit_count, 32'd0);
    check32("rst_miss_miss_count", miss_count, 32'd0);
`endif
    $display("RESET during MISS at 0xC0, late ack ignored");
    mem_auto = 1'b1;
    do_read(32'h0000_00C0, 32'hC0DE_00C0, 1'b1);
    do_read(32'h0000_00C0, 32'hC0DE_00C0, 1'b0);
    do_read(32'h0000_0040, 32'hDEAD_12EF, 1'b1);   // valid bits were cleared

    repeat (3) @(negedge clk);
    check32("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped one-word lines (power of two).
REQ-002 SHALL have parameter INDEX_W, default 4, log2(LINES).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 dcache_read  input  1  load request from the load/store unit; held high until done.
REQ-006 dcache_read_addr  input  32  load byte address; bits [1:0] ignored.
REQ-007 dcache_read_done  output  1  one-cycle pulse; read data valid.
REQ-008 dcache_read_data  output  32  full aligned word; byte/half extraction is done by the requester.
REQ-009 dcache_write  input  1  store commit request from the ROB; held high until done.
REQ-010 dcache_write_addr, dcache_write_data, dcache_write_mask  input  32/32/4  store address, data and byte enables (mask[k] selects byte k).
REQ-011 dcache_write_done  output  1  one-cycle pulse; store accepted by memory.
REQ-012 mem_req, mem_we  output  1/1  memory request and write select.
REQ-013 mem_addr, mem_wdata, mem_wmask  output  32/32/4  memory address (word-aligned), data and byte enables.
REQ-014 mem_ack, mem_rdata  input  1/32  one-cycle completion from memory; read data valid with ack.

Function
REQ-015 Lookup SHALL use index = addr[INDEX_W+1:2], tag = addr[31:INDEX_W+2], per-line valid bit.
REQ-016 FSM states SHALL be IDLE, RESP, MISS, WRITE.
REQ-017 IDLE: dcache_write high -> WRITE; else dcache_read high and hit -> RESP, latching line data; else dcache_read high and miss -> MISS; writes have priority over reads in the same cycle.
REQ-018 RESP SHALL assert dcache_read_done with the latched word for exactly one cycle and return to IDLE; earliest hit done is the cycle after the request is first sampled.
REQ-019 MISS SHALL hold mem_req=1, mem_we=0, mem_addr = read address & ~3 until mem_ack; on ack, fill the line (tag, data, valid=1), drive dcache_read_done=1 with mem_rdata in that same cycle, return to IDLE.
REQ-020 WRITE SHALL hold mem_req=1, mem_we=1, address/data/mask from the store port until mem_ack; on ack pulse dcache_write_done and return to IDLE (write-through).
REQ-021 Store hit SHALL update only masked bytes of the line in the ack cycle; store miss SHALL NOT allocate.
REQ-022 Request inputs SHALL be sampled continuously; a request deasserted by the requester mid-MISS/WRITE is not supported and is not checked.
REQ-023 After any done pulse the FSM SHALL spend at least one cycle in IDLE, so a held request is never answered twice.
REQ-024 mem_req SHALL be 0 in IDLE and RESP; mem outputs stable while mem_req=1 and ack is low.
REQ-025 A store to an index whose tag differs SHALL leave that line unchanged.

Reset
REQ-026 rst SHALL clear all valid bits, force IDLE, and drive dcache_read_done=0, dcache_write_done=0, mem_req=0, mem_we=0, dcache_read_data=0.
REQ-027 rst during MISS or WRITE SHALL abandon the transaction with no line fill and no done pulse; a subsequent mem_ack in IDLE SHALL be ignored.

Configuration
REQ-028 With DCACHE_STATS_EN defined, outputs hit_count and miss_count (32-bit each, zero on reset) SHALL count read hits at IDLE->RESP and read misses at IDLE->MISS, saturating at all-ones; without it these ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-029 Cold read addr 0x0000_0040, memory returns 0xDEAD_BEEF after 3 cycles -> one mem read at 0x40, done with 0xDEAD_BEEF on the ack cycle.
REQ-030 Repeat read 0x0000_0042 -> no mem_req, done one cycle after sampling, data 0xDEAD_BEEF.
REQ-031 Store 0x0000_0040, data 0x0000_1200, mask 4'b0010, then read 0x40 -> mem write with mask 0010, write_done on ack; read hits with 0xDEAD_12EF.
REQ-032 Simultaneous read 0x80 and store 0x100 -> store completes first, then read miss serviced; each done pulses exactly once.
REQ-033 Read 0x0000_0440 (same index as 0x40, different tag) -> miss, line replaced; next read 0x40 misses again.
REQ-034 rst asserted in MISS before ack, ack arrives one cycle later -> no done pulse, line stays invalid; with DCACHE_STATS_EN counters read 0.
